// File: rtl/ula_mc_if.sv
// Request/result bus for ula_mc.
// The issue side drives operands and an opcode; the result side sees the
// output buffer head plus status (busy, occupancy).
interface ula_mc_if #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 2
);
    localparam int FC_W = $clog2(OUT_DEPTH + 1);

    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_W-1:0]     in_a;
    logic [DATA_W-1:0]     in_b;
    logic [2:0]            in_op;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*DATA_W-1:0]   out_data;
    logic                  out_err;
    logic                  busy;
    logic [FC_W-1:0]       fifo_count;

    // ALU side
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_err, busy, fifo_count
    );

    // Issue logic / result consumer side
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_err, busy, fifo_count
    );
endinterface

// File: rtl/ula_mc.sv
// ula_mc: multi-cycle ALU with valid/ready on both sides and an output buffer.
// One operation in flight at a time; its latency depends on the opcode class.
// Results land in a circular buffer so the unit keeps working while the
// consumer stalls. A request is accepted only when a buffer slot is free.
// Optional feature macro: ULA_MC_MUL_EN (opcode 111 = full multiply; when
// undefined opcode 111 is illegal and returns 0 with out_err set).
module ula_mc #(
    parameter int DATA_W    = 16,
    parameter int OUT_DEPTH = 2,
    parameter int LAT_ARITH = 2,
    parameter int LAT_LOGIC = 1,
    parameter int LAT_MUL   = 4
) (
    input  logic     clk_ula,
    input  logic     rst,
    ula_mc_if.slave  bus
);
    localparam int RES_W   = 2 * DATA_W;
    localparam int LAT_AL  = (LAT_ARITH > LAT_LOGIC) ? LAT_ARITH : LAT_LOGIC;
    localparam int LAT_MAX = (LAT_AL > LAT_MUL) ? LAT_AL : LAT_MUL;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);
    localparam int PTR_W   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int FC_W    = $clog2(OUT_DEPTH + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);
    localparam logic [FC_W-1:0]  FC_FULL  = FC_W'(OUT_DEPTH);
    localparam logic [RES_W-1:0] RES_ONE  = RES_W'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   lat_cnt_q;
    logic [DATA_W-1:0]  a_q, b_q;
    logic [2:0]         op_q;

    // Buffer entry layout: {err, data}
    logic [RES_W:0]     mem_q [OUT_DEPTH];
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [FC_W-1:0]    count_q, count_d;

    logic               accept, push, pop;
    logic               push_err;
    logic [RES_W:0]     push_ent, head_ent;

    function automatic logic [CNT_W-1:0] lat_for(input logic [2:0] op);
        if (!op[2])
            return CNT_W'(LAT_ARITH);
        else if (op == 3'b111) begin
`ifdef ULA_MC_MUL_EN
            return CNT_W'(LAT_MUL);
`else
            return CNT_ONE;
`endif
        end else
            return CNT_W'(LAT_LOGIC);
    endfunction

    // Operands are zero-extended first so sums and increments carry into bit DATA_W.
    function automatic logic [RES_W-1:0] alu_result(input logic [2:0] op,
                                                    input logic [DATA_W-1:0] a,
                                                    input logic [DATA_W-1:0] b);
        logic [RES_W-1:0] ax, bx, r;
        ax = RES_W'(a);
        bx = RES_W'(b);
        case (op)
            3'b000:  r = ax + bx;
            3'b001:  r = (a >= b) ? (ax - bx) : (bx - ax);
            3'b010:  r = ax + RES_ONE;
            3'b011:  r = bx + RES_ONE;
            3'b100:  r = ax & bx;
            3'b101:  r = ax | bx;
            3'b110:  r = ax ^ bx;
`ifdef ULA_MC_MUL_EN
            3'b111:  r = ax * bx;
`else
            3'b111:  r = '0;
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

`ifdef ULA_MC_MUL_EN
    assign push_err = 1'b0;
`else
    assign push_err = (op_q == 3'b111);
`endif

    assign bus.in_ready   = (state_q == IDLE) && (count_q < FC_FULL);
    assign accept         = bus.in_valid && bus.in_ready;
    assign push           = (state_q == BUSY) && (lat_cnt_q == CNT_ONE);
    assign bus.out_valid  = (count_q != '0);
    assign pop            = bus.out_valid && bus.out_ready;
    assign bus.busy       = (state_q == BUSY);
    assign bus.fifo_count = count_q;

    assign push_ent     = {push_err, alu_result(op_q, a_q, b_q)};
    assign head_ent     = mem_q[head_q];
    assign bus.out_data = bus.out_valid ? head_ent[RES_W-1:0] : '0;
    assign bus.out_err  = bus.out_valid & head_ent[RES_W];

    // Issue FSM: load the opcode's latency on accept, count down, push on the last cycle.
    always_ff @(posedge clk_ula or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        lat_cnt_q <= lat_for(bus.in_op);
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    lat_cnt_q <= lat_cnt_q - CNT_ONE;
                    if (lat_cnt_q == CNT_ONE)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Operand capture; pins are ignored until the next accept.
    always_ff @(posedge clk_ula) begin
        if (accept) begin
            a_q  <= bus.in_a;
            b_q  <= bus.in_b;
            op_q <= bus.in_op;
        end
    end

    // Buffer storage; contents are only visible through a nonzero count.
    always_ff @(posedge clk_ula) begin
        if (push)
            mem_q[tail_q] <= push_ent;
    end

    // Occupancy: simultaneous push and pop cancel out.
    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + FC_W'(1);
            2'b01:   count_d = count_q - FC_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Buffer pointers and count, wrapping modulo OUT_DEPTH.
    always_ff @(posedge clk_ula or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push)
                tail_q <= ptr_inc(tail_q);
            if (pop)
                head_q <= ptr_inc(head_q);
            count_q <= count_d;
        end
    end
endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc (DATA_W=16, OUT_DEPTH=2, default latencies).
// Expected results are queued when a request is issued and compared when the
// consumer pops them.
module tb_ula_mc;
    localparam int DATA_W    = 16;
    localparam int OUT_DEPTH = 2;

    typedef struct packed {
        logic        err;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] data;
        logic        err;
        int          lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ula_mc_if #(.DATA_W(DATA_W), .OUT_DEPTH(OUT_DEPTH)) ifc ();

    ula_mc #(
        .DATA_W   (DATA_W),
        .OUT_DEPTH(OUT_DEPTH),
        .LAT_ARITH(2),
        .LAT_LOGIC(1),
        .LAT_MUL  (4)
    ) dut (
        .clk_ula(clk),
        .rst    (rst),
        .bus    (ifc.slave)
    );

    always #5 clk = ~clk;

    int   n_cmp  = 0;
    int   n_fail = 0;
    exp_t q[$];
    bit   rnd_on = 1'b0;
    vec_t vecs[10];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: a pop happens on the next rising edge, compare the head now.
    always @(negedge clk) begin
        if (!rst && ifc.out_valid && ifc.out_ready) begin
            if (q.size() == 0) begin
                check("spurious_result", 64'(ifc.out_data), 64'hDEAD);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("sb_out_data", 64'(ifc.out_data), 64'(e.data));
                check("sb_out_err", 64'(ifc.out_err), 64'(e.err));
            end
        end
    end

    // Random consumer stalls during the streaming phase.
    always @(posedge clk) begin
        if (rnd_on) begin
            #1;
            ifc.out_ready = 1'($urandom_range(0, 1));
        end
    end

    function automatic exp_t model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        longint la, lb, r;
        exp_t e;
        la = longint'(a);
        lb = longint'(b);
        e.err = 1'b0;
        case (op)
            3'd0: r = la + lb;
            3'd1: r = (la > lb) ? la - lb : lb - la;
            3'd2: r = la + 1;
            3'd3: r = lb + 1;
            3'd4: r = la & lb;
            3'd5: r = la | lb;
            3'd6: r = la ^ lb;
            default: begin
`ifdef ULA_MC_MUL_EN
                r = la * lb;
`else
                r = 0;
                e.err = 1'b1;
`endif
            end
        endcase
        e.data = r[31:0];
        return e;
    endfunction

    // Called #1 after a rising edge; returns #1 after the accepting edge.
    task automatic issue(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         input exp_t e);
        int t;
        t = 0;
        while (!ifc.in_ready && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 200) check("issue_timeout", 64'd1, 64'd0);
        ifc.in_valid = 1'b1;
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_op    = op;
        q.push_back(e);
        @(posedge clk);
        #1;
        ifc.in_valid = 1'b0;
        ifc.in_a     = $urandom;
        ifc.in_b     = $urandom;
        ifc.in_op    = 3'($urandom);
    endtask

    task automatic wait_count(input int n, input string nm);
        int t;
        t = 0;
        while (ifc.fifo_count != n && t < 50) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 50) check(nm, 64'(ifc.fifo_count), 64'(n));
    endtask

    task automatic drain(input string nm);
        int t;
        ifc.out_ready = 1'b1;
        t = 0;
        while (q.size() != 0 && t < 100) begin
            @(posedge clk);
            #1;
            t++;
        end
        check(nm, 64'(q.size()), 64'd0);
        check({nm, "_count"}, 64'(ifc.fifo_count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc;
        bit   seen;
        exp_t e;
        logic [2:0]  rop;
        logic [15:0] ra, rb;

        vecs[0] = '{"add_carry", 3'b000, 16'hFFFF, 16'h0001, 32'h0001_0000, 1'b0, 2};
        vecs[1] = '{"absdiff_lo", 3'b001, 16'd5, 16'd9, 32'd4, 1'b0, 2};
        vecs[2] = '{"absdiff_hi", 3'b001, 16'd9, 16'd5, 32'd4, 1'b0, 2};
        vecs[3] = '{"xor", 3'b110, 16'h00F0, 16'h0FF0, 32'h0000_0F00, 1'b0, 1};
        vecs[4] = '{"inc_a_carry", 3'b010, 16'hFFFF, 16'h1111, 32'h0001_0000, 1'b0, 2};
        vecs[5] = '{"inc_b", 3'b011, 16'hAAAA, 16'h1234, 32'h0000_1235, 1'b0, 2};
        vecs[6] = '{"and", 3'b100, 16'hF0F0, 16'hFF00, 32'h0000_F000, 1'b0, 1};
        vecs[7] = '{"or", 3'b101, 16'hF0F0, 16'h0F0F, 32'h0000_FFFF, 1'b0, 1};
`ifdef ULA_MC_MUL_EN
        vecs[8] = '{"mul", 3'b111, 16'd300, 16'd200, 32'd60000, 1'b0, 4};
`else
        vecs[8] = '{"mul_illegal", 3'b111, 16'd300, 16'd200, 32'd0, 1'b1, 1};
`endif
        vecs[9] = '{"add_zero", 3'b000, 16'h0000, 16'h0000, 32'd0, 1'b0, 2};

        ifc.in_valid  = 1'b0;
        ifc.in_a      = '0;
        ifc.in_b      = '0;
        ifc.in_op     = '0;
        ifc.out_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("rst_out_data", 64'(ifc.out_data), 64'd0);
        check("rst_out_err", 64'(ifc.out_err), 64'd0);
        check("rst_busy", 64'(ifc.busy), 64'd0);
        check("rst_fifo_count", 64'(ifc.fifo_count), 64'd0);
        check("rst_in_ready", 64'(ifc.in_ready), 64'd1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-operation with one result already buffered
        issue(3'b010, 16'd1, 16'd0, model(3'b010, 16'd1, 16'd0));
        wait_count(1, "midrst_prefill");
        issue(3'b000, 16'd3, 16'd4, model(3'b000, 16'd3, 16'd4));
        check("midrst_busy", 64'(ifc.busy), 64'd1);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(ifc.out_valid), 64'd0);
        check("midrst_out_data", 64'(ifc.out_data), 64'd0);
        check("midrst_out_err", 64'(ifc.out_err), 64'd0);
        check("midrst_busy_clr", 64'(ifc.busy), 64'd0);
        check("midrst_fifo_count", 64'(ifc.fifo_count), 64'd0);
        check("midrst_in_ready", 64'(ifc.in_ready), 64'd1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (ifc.out_valid) seen = 1'b1;
        end
        check("postrst_no_result", 64'(seen), 64'd0);
        @(posedge clk);
        #1;
        check("postrst_in_ready", 64'(ifc.in_ready), 64'd1);

        // Backpressure: fill both slots, then a single pop
        ifc.out_ready = 1'b0;
        issue(3'b010, 16'd7, 16'd0, '{1'b0, 32'd8});
        issue(3'b011, 16'd0, 16'd7, '{1'b0, 32'd8});
        wait_count(2, "bp_fill");
        check("bp_fifo_count", 64'(ifc.fifo_count), 64'd2);
        check("bp_in_ready", 64'(ifc.in_ready), 64'd0);
        check("bp_out_valid", 64'(ifc.out_valid), 64'd1);
        check("bp_head", 64'(ifc.out_data), 64'd8);
        @(posedge clk);
        #1;
        check("bp_head_hold", 64'(ifc.out_data), 64'd8);
        check("bp_in_ready_hold", 64'(ifc.in_ready), 64'd0);
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        ifc.out_ready = 1'b0;
        check("bp_after_pop_count", 64'(ifc.fifo_count), 64'd1);
        check("bp_after_pop_in_ready", 64'(ifc.in_ready), 64'd1);
        drain("bp_drain");

        // Table: each opcode class with its latency, consumer always ready
        ifc.out_ready = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) begin
            e.data = vecs[i].data;
            e.err  = vecs[i].err;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, e);
            cyc = 0;
            do begin
                @(negedge clk);
                cyc++;
            end while (!ifc.out_valid && cyc < 20);
            // First negedge after the accepting edge precedes edge k+1.
            check($sformatf("lat_%s", vecs[i].name), 64'(cyc), 64'(vecs[i].lat + 1));
            @(posedge clk);
            #1;
            check($sformatf("popthru_%s", vecs[i].name), 64'(ifc.out_valid), 64'd0);
        end
        check("table_sb_empty", 64'(q.size()), 64'd0);

        // Random stream with random stalls: order, wrap-around, no loss/dup
        rnd_on = 1'b1;
        for (int i = 0; i < 10; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = 16'($urandom);
            rb  = 16'($urandom);
            issue(rop, ra, rb, model(rop, ra, rb));
        end
        rnd_on = 1'b0;
        @(posedge clk);
        #2;
        drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
